// File: rtl/frame_buf_ptr_sched.sv
// frame_buf_ptr_sched: frame-slot scheduler for the DDR3 frame buffer (write/read slot pointers, stored-frame count, frame depth).
// Optional feature macro FRAME_BUF_OVERWRITE_EN: a full-buffer write discards the oldest frame instead of being dropped.
module frame_buf_ptr_sched #(
    parameter int PTR_WIDTH    = 2,
    parameter int SHORT_REG_WD = 16
) (
    input  logic                    clk_frame_buf,
    input  logic                    reset_frame_buf,
    input  logic                    i_stream_enable,
    input  logic [SHORT_REG_WD-1:0] iv_frame_depth,
    input  logic                    i_wr_req,
    input  logic                    i_wr_done,
    input  logic                    i_rd_req,
    input  logic                    i_rd_done,
    output logic                    o_wr_grant,
    output logic [PTR_WIDTH-1:0]    ov_wr_ptr,
    output logic                    o_wr_drop,
    output logic                    o_rd_grant,
    output logic [PTR_WIDTH-1:0]    ov_rd_ptr,
    output logic [PTR_WIDTH:0]      ov_frame_cnt,
    output logic                    o_frame_avail,
    output logic                    o_proto_err
);
    localparam int                      CNT_W         = PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0]        MAX_SLOTS     = CNT_W'(2 ** PTR_WIDTH);
    localparam logic [SHORT_REG_WD-1:0] MAX_SLOTS_REQ = SHORT_REG_WD'(2 ** PTR_WIDTH);

    typedef enum logic {W_IDLE, W_ACTIVE} wr_state_t;
    typedef enum logic {R_IDLE, R_ACTIVE} rd_state_t;

    wr_state_t            r_wr_state, w_wr_state_nxt;
    rd_state_t            r_rd_state, w_rd_state_nxt;
    logic [CNT_W-1:0]     r_depth, w_depth_clamped;
    logic [CNT_W-1:0]     r_frame_cnt, w_frame_cnt_nxt, w_cnt_upd;
    logic [PTR_WIDTH-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic                 r_wr_grant, r_wr_drop, r_rd_grant, r_proto_err;
    logic                 w_wr_grant_nxt, w_wr_drop_nxt, w_rd_grant_nxt, w_proto_err_nxt;
    logic                 w_flush, w_wr_fin, w_rd_fin, w_wr_free, w_rd_free;
    logic                 w_full, w_wr_accept, w_rd_accept, w_overwrite;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p,
                                                     input logic [CNT_W-1:0]     d);
        logic [CNT_W-1:0] n;
        n = {1'b0, p} + CNT_W'(1);
        return (n >= d) ? '0 : n[PTR_WIDTH-1:0];
    endfunction

    // A done completes before a same-cycle request is judged, so the request sees the freed FSM and updated count.
    assign w_flush   = !i_stream_enable && (r_wr_state == W_IDLE) && (r_rd_state == R_IDLE);
    assign w_wr_fin  = (r_wr_state == W_ACTIVE) && i_wr_done;
    assign w_rd_fin  = (r_rd_state == R_ACTIVE) && i_rd_done;
    assign w_wr_free = (r_wr_state == W_IDLE) || w_wr_fin;
    assign w_rd_free = (r_rd_state == R_IDLE) || w_rd_fin;
    assign w_cnt_upd = r_frame_cnt + CNT_W'(w_wr_fin) - CNT_W'(w_rd_fin);
    assign w_full    = (w_cnt_upd >= r_depth);

    assign w_rd_accept = !w_flush && i_rd_req && w_rd_free && (w_cnt_upd != '0);

`ifdef FRAME_BUF_OVERWRITE_EN
    assign w_overwrite = !w_flush && i_wr_req && w_wr_free && i_stream_enable && w_full
                         && (r_rd_state == R_IDLE) && !w_rd_accept;
`else
    assign w_overwrite = 1'b0;
`endif

    assign w_wr_accept = !w_flush && i_wr_req && w_wr_free && i_stream_enable
                         && (!w_full || w_overwrite);

    always_comb begin
        w_depth_clamped = CNT_W'(iv_frame_depth);
        if (iv_frame_depth == '0)
            w_depth_clamped = CNT_W'(1);
        else if (iv_frame_depth > MAX_SLOTS_REQ)
            w_depth_clamped = MAX_SLOTS;
    end

    // State register plus the slot bookkeeping and registered output pulses.
    always_ff @(posedge clk_frame_buf) begin
        if (reset_frame_buf) begin
            r_wr_state  <= W_IDLE;
            r_rd_state  <= R_IDLE;
            r_depth     <= CNT_W'(1);
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_frame_cnt <= '0;
            r_wr_grant  <= 1'b0;
            r_wr_drop   <= 1'b0;
            r_rd_grant  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            r_wr_state  <= w_wr_state_nxt;
            r_rd_state  <= w_rd_state_nxt;
            r_depth     <= w_flush ? w_depth_clamped : r_depth;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_wr_grant  <= w_wr_grant_nxt;
            r_wr_drop   <= w_wr_drop_nxt;
            r_rd_grant  <= w_rd_grant_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        w_wr_state_nxt  = r_wr_state;
        w_rd_state_nxt  = r_rd_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_frame_cnt_nxt = w_cnt_upd - CNT_W'(w_overwrite);

        if (w_wr_accept)
            w_wr_state_nxt = W_ACTIVE;
        else if (w_wr_fin)
            w_wr_state_nxt = W_IDLE;

        if (w_rd_accept)
            w_rd_state_nxt = R_ACTIVE;
        else if (w_rd_fin)
            w_rd_state_nxt = R_IDLE;

        if (w_wr_fin)
            w_wr_ptr_nxt = ptr_inc(r_wr_ptr, r_depth);
        if (w_rd_fin || w_overwrite)
            w_rd_ptr_nxt = ptr_inc(r_rd_ptr, r_depth);

        if (w_flush) begin
            w_wr_ptr_nxt    = '0;
            w_rd_ptr_nxt    = '0;
            w_frame_cnt_nxt = '0;
        end
    end

    always_comb begin
        w_wr_grant_nxt  = w_wr_accept;
        w_rd_grant_nxt  = w_rd_accept;
        w_wr_drop_nxt   = !w_flush && i_wr_req && w_wr_free && !w_wr_accept;
        w_proto_err_nxt = (i_wr_req && !w_wr_free)
                       || (i_rd_req && !w_rd_free)
                       || (i_wr_done && (r_wr_state == W_IDLE))
                       || (i_rd_done && (r_rd_state == R_IDLE))
                       || (!w_flush && i_rd_req && w_rd_free && (w_cnt_upd == '0));
    end

    assign o_wr_grant    = r_wr_grant;
    assign o_wr_drop     = r_wr_drop;
    assign o_rd_grant    = r_rd_grant;
    assign o_proto_err   = r_proto_err;
    assign ov_wr_ptr     = r_wr_ptr;
    assign ov_rd_ptr     = r_rd_ptr;
    assign ov_frame_cnt  = r_frame_cnt;
    assign o_frame_avail = (r_frame_cnt != '0) && (r_rd_state == R_IDLE);

endmodule
